// File: rtl/fetch_queue_unit.sv
// Instruction fetch queue: issues sequential fetches from a fetch PC and buffers
// {pc, inst} pairs in a circular queue ahead of decode. A redirect flushes the queue.
module fetch_queue_unit #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_ready,
  input  logic [31:0]                imem_data,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       dec_stall,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [XLEN-1:0]            inst_pc,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] mem_pc_q   [DEPTH];
  logic [31:0]     mem_inst_q [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            push, pop;

  // Outputs come only from registered state; nothing from imem_* or dec_stall leaks through.
  assign imem_req   = !rst && (count_q != FULL);
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? mem_inst_q[rd_ptr_q] : NOP_INST;
  assign inst_pc    = inst_valid ? mem_pc_q[rd_ptr_q] : '0;
  assign count      = count_q;

  assign push = imem_req && imem_ready && !redirect;
  assign pop  = inst_valid && !dec_stall && !redirect;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      // Flush wins over any fetch completing in the same cycle.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Entry payload carries no reset; validity is tracked by count/pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
      mem_inst_q[wr_ptr_q] <= imem_data;
    end
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: queue-based scoreboard checked every cycle plus
// directed scenarios; a second XLEN=32 instance checks PC wraparound.
module tb_fetch_queue_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] BAD = 32'hBAD0BAD0;

  logic clk = 0;
  always #5 clk = ~clk;

  logic        rst, imem_ready, redirect, dec_stall, poison;
  logic [63:0] redirect_pc;
  logic        imem_req, inst_valid;
  logic [63:0] imem_addr, inst_pc;
  logic [31:0] imem_data, inst;
  logic [2:0]  count;

  logic        rst2, ready2, redirect2, stall2;
  logic [31:0] rpc2;
  logic        req2, valid2;
  logic [31:0] addr2, data2, inst2, ipc2;
  logic [2:0]  count2;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A0003;
  endfunction

  assign imem_data = poison ? BAD : mem_word(imem_addr);
  assign data2     = mem_word({32'h0, addr2});

  fetch_queue_unit #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .dec_stall(dec_stall), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .count(count));

  fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(ready2), .imem_data(data2), .redirect(redirect2),
    .redirect_pc(rpc2), .dec_stall(stall2), .inst_valid(valid2),
    .inst(inst2), .inst_pc(ipc2), .count(count2));

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        sb[$];
  logic [63:0] mpc;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour at a rising edge, driven by bench inputs and bench state only.
  task automatic model_step();
    logic req, vld;
    if (rst) begin
      sb.delete();
      mpc = 64'h0;
    end else begin
      req = (sb.size() < DEPTH);
      vld = (sb.size() != 0);
      if (redirect) begin
        sb.delete();
        mpc = redirect_pc;
      end else begin
        if (vld && !dec_stall) void'(sb.pop_front());
        if (req && imem_ready) begin
          sb.push_back('{pc: mpc, ins: (poison ? BAD : mem_word(mpc))});
          mpc = mpc + 64'd4;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("count", 64'(count), 64'(sb.size()));
    chk("imem_req", 64'(imem_req), 64'(!rst && sb.size() < DEPTH));
    chk("imem_addr", imem_addr, mpc);
    chk("inst_valid", 64'(inst_valid), 64'(sb.size() != 0));
    chk("inst", 64'(inst), 64'(sb.size() != 0 ? sb[0].ins : NOP));
    chk("inst_pc", inst_pc, sb.size() != 0 ? sb[0].pc : 64'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [63:0] a;
    logic        rdy;
    rst = 1; imem_ready = 0; redirect = 0; dec_stall = 0; poison = 0; redirect_pc = '0;
    rst2 = 1; ready2 = 0; redirect2 = 0; stall2 = 0; rpc2 = '0;
    sb.delete(); mpc = 64'h0;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'(NOP));
    chk("rst_pc", inst_pc, 64'h0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_addr", imem_addr, 64'h0);

    // Streaming fetch: one entry in flight, head PC advances by 4 each cycle.
    rst = 0; imem_ready = 1; dec_stall = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_pc", inst_pc, 64'(i * 4));
    end
    chk("seq_count", 64'(count), 64'd1);

    // Stall from reset until full.
    rst = 1; tick(); rst = 0; dec_stall = 1;
    repeat (10) tick();
    chk("full_count", 64'(count), 64'd4);
    chk("full_req", 64'(imem_req), 64'd0);
    chk("full_addr", imem_addr, 64'h10);

    // Redirect from full.
    redirect = 1; redirect_pc = 64'h200; tick(); redirect = 0;
    chk("redir_count", 64'(count), 64'd0);
    chk("redir_inst", 64'(inst), 64'(NOP));
    chk("redir_addr", imem_addr, 64'h200);
    chk("redir_valid", 64'(inst_valid), 64'd0);
    tick();

    // Redirect concurrent with a completing fetch: the fetched word is dropped.
    poison = 1; redirect = 1; redirect_pc = 64'h300; imem_ready = 1; tick();
    poison = 0; redirect = 0; dec_stall = 0;
    chk("race_addr", imem_addr, 64'h300);
    repeat (8) begin
      tick();
      chk("no_poison", 64'(inst == BAD), 64'd0);
    end

    // Handshake gaps: address must hold on ready=0 cycles.
    redirect = 1; redirect_pc = 64'h40; tick(); redirect = 0;
    for (int i = 0; i < 12; i++) begin
      rdy = (i % 2 == 0);
      imem_ready = rdy;
      a = imem_addr;
      tick();
      if (!rdy) chk("addr_hold", imem_addr, a);
    end

    // Reset while a fetch is pending: nothing gets written.
    imem_ready = 0; tick();
    rst = 1; imem_ready = 1; tick();
    chk("rst_mid_count", 64'(count), 64'd0);
    rst = 0; imem_ready = 0; tick();
    chk("rst_mid_addr", imem_addr, 64'h0);
    chk("rst_mid_valid", 64'(inst_valid), 64'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      imem_ready  = 1'($urandom_range(0, 1));
      dec_stall   = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 64'({$urandom_range(0, 1023), 2'b00});
      tick();
    end
    redirect = 0; imem_ready = 0; dec_stall = 1;

    // XLEN=32 PC wraparound.
    rst2 = 0; redirect2 = 1; rpc2 = 32'hFFFFFFFC; ready2 = 1; stall2 = 0;
    tick();
    redirect2 = 0;
    chk("w32_valid", 64'(valid2), 64'd0);
    chk("w32_addr", 64'(addr2), 64'hFFFFFFFC);
    tick();
    chk("w32_pc0", 64'(ipc2), 64'hFFFFFFFC);
    chk("w32_inst0", 64'(inst2), 64'(mem_word(64'hFFFFFFFC)));
    tick();
    chk("w32_pc1", 64'(ipc2), 64'h0);
    chk("w32_inst1", 64'(inst2), 64'(mem_word(64'h0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 The parameter XLEN SHALL default to 64 and set the program-counter and address width in bits.
REQ-002 The parameter DEPTH SHALL default to 4 and set the number of queue entries; legal values are powers of two, 2 to 16.
REQ-003 The parameter RESET_PC SHALL default to 0 and set the first fetch address after reset.
REQ-004 The parameter NOP_INST SHALL default to 32'h00000013 and set the instruction presented while the queue is empty.
REQ-005 `clk` SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-006 `rst` SHALL be an input, 1 bit wide, and is the reset; it is asynchronous and active-high.
REQ-007 `imem_req` SHALL be an output, 1 bit wide, and requests an instruction-memory fetch.
REQ-008 `imem_addr` SHALL be an output, XLEN bits wide, and carries the fetch address (the current fetch PC).
REQ-009 `imem_ready` SHALL be an input, 1 bit wide; a fetch completes in any cycle where `imem_req` and `imem_ready` are both 1.
REQ-010 `imem_data` SHALL be an input, 32 bits wide, and carries the fetched instruction; it is valid in the cycle `imem_ready` is 1.
REQ-011 `redirect` SHALL be an input, 1 bit wide, and signals a control-transfer redirect (taken branch, jal, jalr).
REQ-012 `redirect_pc` SHALL be an input, XLEN bits wide, and carries the redirect target.
REQ-013 `dec_stall` SHALL be an input, 1 bit wide; the decode stage holds the current instruction while it is 1.
REQ-014 `inst_valid` SHALL be an output, 1 bit wide, and is 1 when the head entry is valid.
REQ-015 `inst` SHALL be an output, 32 bits wide, and carries the head instruction, or NOP_INST when the queue is empty.
REQ-016 `inst_pc` SHALL be an output, XLEN bits wide, and carries the head entry's PC, or 0 when the queue is empty.
REQ-017 `count` SHALL be an output, log2(DEPTH)+1 bits wide, and carries the number of valid entries.

Function
REQ-018 The block SHALL hold a circular queue of DEPTH entries, each {pc[XLEN-1:0], inst[31:0]}, with write pointer, read pointer and occupancy counter.
REQ-019 `imem_req` SHALL be 1 exactly when `rst` is 0 and `count` < DEPTH; it SHALL be 0 while the queue is full.
REQ-020 `imem_addr` SHALL equal the fetch PC register and SHALL remain stable while `imem_req` is 1 and `imem_ready` is 0.
REQ-021 Push: on `imem_req` & `imem_ready` & !`redirect`, the block SHALL write {fetch PC, `imem_data`} at the write pointer, advance the write pointer, and set fetch PC to fetch PC + 4 (modulo 2^XLEN, wrapping silently).
REQ-022 Pop: on `inst_valid` & !`dec_stall` & !`redirect`, the block SHALL advance the read pointer.
REQ-023 On a push and a pop in the same cycle, `count` SHALL remain unchanged and both pointers SHALL advance.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 `inst_valid`, `inst` and `inst_pc` SHALL be driven from the head register combinationally, with no combinational path from `imem_*` or `dec_stall` to them.
REQ-026 Redirect SHALL take priority over push and pop: on `redirect` = 1 the queue SHALL be flushed (pointers and `count` to 0), any completing fetch SHALL be discarded, and the fetch PC SHALL load `redirect_pc`.
REQ-027 In the cycle after a redirect, `inst_valid` SHALL be 0 and `imem_addr` SHALL equal the captured `redirect_pc`.
REQ-028 Latency SHALL be one cycle: a completed fetch into an empty queue SHALL appear on the outputs in the next cycle.
REQ-029 With `dec_stall` held at 1, the head entry and its outputs SHALL remain unchanged.

Reset
REQ-030 While `rst` is 1: fetch PC SHALL be RESET_PC, pointers and `count` SHALL be 0, `imem_req` and `inst_valid` SHALL be 0, `inst` SHALL be NOP_INST, and `inst_pc` SHALL be 0.
REQ-031 Assertion of `rst` mid-fetch SHALL abandon the fetch, with no entry written.
REQ-032 Entry storage SHALL need no reset; only the valid state is reset.

Verification
REQ-033 The bench SHALL cover: reset release, `imem_ready` = 1 every cycle, `dec_stall` = 0 -> first `inst_pc` = 0, then 4, 8, 12 on consecutive cycles, with `count` settling at 1.
REQ-034 The bench SHALL cover: `dec_stall` = 1 for 10 cycles, DEPTH = 4 -> `count` reaches 4, `imem_req` drops to 0, and `imem_addr` holds 0x10.
REQ-035 The bench SHALL cover: full queue and `redirect` = 1 with `redirect_pc` = 0x200 -> next cycle `count` = 0, `inst` = 0x00000013, and `imem_addr` = 0x200.
REQ-036 The bench SHALL cover: `redirect` in the same cycle as a completing fetch -> the fetched word never appears on `inst`.
REQ-037 The bench SHALL cover: `imem_ready` toggling 1,0,1,0 -> `imem_addr` stable during the 0 cycles and no duplicate or missing PCs.
REQ-038 The bench SHALL cover: XLEN = 32 with `redirect_pc` = 0xFFFFFFFC -> next fetched `inst_pc` values are 0xFFFFFFFC, then 0x00000000.
